// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter register and single-outstanding instruction
//               fetch sequencer. Holds the current PC, requests the word at
//               that address, captures it when memory answers, then waits for
//               the PC-update mux to commit the next word-aligned PC. A
//               misaligned next-PC latches a sticky error that only reset
//               clears.
//
// Ports
//   clk          in   1   rising-edge clock for all state
//   reset        in   1   synchronous, active-high reset (highest priority)
//   iaddr_wdata  in   32  next-PC value from the PC-update mux
//   pc_update_en in   1   request to commit iaddr_wdata as the new PC
//   stall        in   1   blocks a PC commit while high
//   imem_rdata   in   32  instruction word returned by instruction memory
//   imem_ready   in   1   imem_rdata is valid for iaddr this cycle
//   iaddr        out  32  current PC (registered)
//   imem_req     out  1   fetch request for iaddr (registered)
//   instr        out  32  captured instruction word (registered)
//   instr_valid  out  1   instr holds the word fetched from iaddr (registered)
//   misalign_err out  1   sticky misaligned-next-PC error (registered)
//   fetch_count  out  32  completed fetches since reset, wraps silently
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iaddr_wdata,
    input  logic        pc_update_en,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] iaddr,
    output logic        imem_req,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    // Canonical RISC-V NOP (addi x0, x0, 0); instr shows this until the
    // first real fetch lands.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // The PC must always be word aligned; the low bits of the parameter are
    // dropped so a mis-set RESET_PC can never produce a misaligned fetch.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,   // fetch outstanding, waiting for imem_ready
        ST_HOLD = 2'b01,   // instruction captured, waiting for next-PC commit
        ST_ERR  = 2'b10    // misaligned next-PC seen, locked until reset
    } state_t;

    state_t      state_q,        state_d;
    logic [31:0] iaddr_q,        iaddr_d;
    logic [31:0] instr_q,        instr_d;
    logic [31:0] fetch_count_q,  fetch_count_d;
    logic        misalign_q,     misalign_d;
    logic        imem_req_q,     imem_req_d;
    logic        instr_valid_q,  instr_valid_d;

    logic        commit_req;
    logic        commit_aligned;

    // A commit is only meaningful in HOLD; stall masks it entirely.
    assign commit_req     = (state_q == ST_HOLD) && pc_update_en && !stall;
    assign commit_aligned = (iaddr_wdata[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // Next-state and next-output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        iaddr_d       = iaddr_q;
        instr_d       = instr_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;

        case (state_q)
            ST_REQ: begin
                // pc_update_en is deliberately not looked at here: the PC
                // must not move under an outstanding fetch.
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // imem_ready is ignored: instr stays the word for iaddr.
                if (commit_req) begin
                    if (commit_aligned) begin
                        // A self-loop (wdata == iaddr) is a normal commit
                        // and causes a refetch of the same word.
                        iaddr_d = iaddr_wdata;
                        state_d = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                // Terminal until reset; every input is ignored.
                misalign_d = 1'b1;
            end

            default: begin
                // Unused encoding: recover by restarting the fetch.
                state_d = ST_REQ;
            end
        endcase

        // Status outputs are decoded from the state being entered so that
        // the registered copies line up with the state register.
        imem_req_d    = (state_d == ST_REQ);
        instr_valid_d = (state_d == ST_HOLD);
    end

    // ------------------------------------------------------------------
    // State and output registers; reset overrides every other input,
    // including an imem_ready arriving in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_REQ;
            iaddr_q       <= RESET_PC_ALIGNED;
            instr_q       <= NOP_INSTR;
            fetch_count_q <= 32'd0;
            misalign_q    <= 1'b0;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            iaddr_q       <= iaddr_d;
            instr_q       <= instr_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign iaddr        = iaddr_q;
    assign imem_req     = imem_req_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed, scoreboard-checked bench for pc_fetch_unit. The
//               stimulus process drives one input vector per cycle and pushes
//               the hand-computed post-edge state; the monitor pops and
//               compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddr_wdata;
    logic        pc_update_en;
    logic        stall;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] iaddr;
    logic        imem_req;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .iaddr_wdata  (iaddr_wdata),
        .pc_update_en (pc_update_en),
        .stall        (stall),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .iaddr        (iaddr),
        .imem_req     (imem_req),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] ia;
        logic [31:0] ins;
        logic        req;
        logic        vld;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare after every rising edge that has an expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "iaddr",        iaddr,                 e.ia);
            chk(e.nm, "instr",        instr,                 e.ins);
            chk(e.nm, "imem_req",     {31'd0, imem_req},     {31'd0, e.req});
            chk(e.nm, "instr_valid",  {31'd0, instr_valid},  {31'd0, e.vld});
            chk(e.nm, "misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
            chk(e.nm, "fetch_count",  fetch_count,           e.cnt);
        end
    end

    task automatic push(input string nm, input logic [31:0] ia, input logic [31:0] ins,
                        input logic req, input logic vld, input logic err,
                        input logic [31:0] cnt);
        exp_t e;
        e.nm = nm; e.ia = ia; e.ins = ins;
        e.req = req; e.vld = vld; e.err = err; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic pu, input logic st, input logic rdy,
                         input logic [31:0] wd, input logic [31:0] rd);
        reset = r; pc_update_en = pu; stall = st; imem_ready = rdy;
        iaddr_wdata = wd; imem_rdata = rd;
    endtask

    // One cycle: drive at the falling edge, expect the state after the next rise.
    task automatic cyc(input logic r, input logic pu, input logic st, input logic rdy,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input string nm, input logic [31:0] ia, input logic [31:0] ins,
                       input logic req, input logic vld, input logic err,
                       input logic [31:0] cnt);
        @(negedge clk);
        drive(r, pu, st, rdy, wd, rd);
        push(nm, ia, ins, req, vld, err, cnt);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset with imem_ready high: nothing may be captured.
        cyc(1,0,0,1, 32'h0, 32'hAAAA_AAAA, "reset",      32'h0, NOP, 1,0,0, 32'd0);
        cyc(1,0,0,1, 32'h0, 32'hAAAA_AAAA, "reset2",     32'h0, NOP, 1,0,0, 32'd0);
        // First fetch right after reset release.
        cyc(0,0,0,1, 32'h0, 32'h0050_0093, "first_fetch", 32'h0, 32'h0050_0093, 0,1,0, 32'd1);
        // imem_ready in HOLD ignored.
        cyc(0,0,0,1, 32'h0, 32'hDEAD_BEEF, "hold_rdy",   32'h0, 32'h0050_0093, 0,1,0, 32'd1);
        // Commit PC=4.
        cyc(0,1,0,0, 32'h4, 32'h0, "commit4",           32'h4, 32'h0050_0093, 1,0,0, 32'd1);
        // Wait in REQ three cycles; pc_update_en ignored there.
        for (int i = 0; i < 3; i++)
            cyc(0,1,0,0, 32'h8, 32'h0, "req_wait",      32'h4, 32'h0050_0093, 1,0,0, 32'd1);
        cyc(0,0,0,1, 32'h0, 32'h00A0_0113, "fetch2",    32'h4, 32'h00A0_0113, 0,1,0, 32'd2);
        // Stalled commit for four cycles.
        for (int i = 0; i < 4; i++)
            cyc(0,1,1,0, 32'h100, 32'h0, "stall",       32'h4, 32'h00A0_0113, 0,1,0, 32'd2);
        cyc(0,1,0,0, 32'h100, 32'h0, "unstall",         32'h100, 32'h00A0_0113, 1,0,0, 32'd2);
        cyc(0,0,0,1, 32'h0, 32'h1111_1111, "fetch3",    32'h100, 32'h1111_1111, 0,1,0, 32'd3);
        // Self-loop commit refetches the same address.
        cyc(0,1,0,0, 32'h100, 32'h0, "selfloop",        32'h100, 32'h1111_1111, 1,0,0, 32'd3);
        cyc(0,0,0,1, 32'h0, 32'h2222_2222, "refetch",   32'h100, 32'h2222_2222, 0,1,0, 32'd4);
        cyc(0,1,0,0, 32'h40, 32'h0, "commit40",         32'h40, 32'h2222_2222, 1,0,0, 32'd4);
        // Reset while a fetch at 0x40 is being answered.
        cyc(1,0,0,1, 32'h0, 32'h3333_3333, "reset_midreq", 32'h0, NOP, 1,0,0, 32'd0);
        cyc(0,0,0,1, 32'h0, 32'h0000_0063, "fetch_a",   32'h0, 32'h0000_0063, 0,1,0, 32'd1);
        // Misaligned next-PC -> ERR, sticky.
        cyc(0,1,0,0, 32'h6, 32'h0, "misalign",          32'h0, 32'h0000_0063, 0,0,1, 32'd1);
        cyc(0,1,0,1, 32'h8, 32'h44, "err_sticky",       32'h0, 32'h0000_0063, 0,0,1, 32'd1);
        cyc(0,1,0,1, 32'hC, 32'h44, "err_sticky2",      32'h0, 32'h0000_0063, 0,0,1, 32'd1);
        cyc(1,0,0,0, 32'h0, 32'h0, "reset_err",         32'h0, NOP, 1,0,0, 32'd0);
        cyc(0,0,0,1, 32'h0, 32'h55, "fetch_b",          32'h0, 32'h55, 0,1,0, 32'd1);

        // Preload the counter to all-ones through its next-state value.
        @(negedge clk);
        drive(0,0,0,0, 32'h0, 32'h0);
        force dut.fetch_count_d = 32'hFFFF_FFFF;
        push("preload", 32'h0, 32'h55, 0,1,0, 32'hFFFF_FFFF);
        @(negedge clk);
        release dut.fetch_count_d;
        drive(0,1,0,0, 32'h8, 32'h0);
        push("commit8", 32'h8, 32'h55, 1,0,0, 32'hFFFF_FFFF);
        cyc(0,0,0,1, 32'h0, 32'h66, "wrap",             32'h8, 32'h66, 0,1,0, 32'd0);
        cyc(0,0,0,0, 32'h0, 32'h0, "post_wrap",         32'h8, 32'h66, 0,1,0, 32'd0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
